// File: rtl/ysyx_25040105_ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state type, the buffered entry layout and the default boot address.
package ysyx_25040105_ifetch_pkg;

    localparam int unsigned AddrWidth  = 32;
    localparam int unsigned InstWidth  = 32;
    localparam int unsigned EntryWidth = AddrWidth + InstWidth;

    localparam logic [AddrWidth-1:0] DefaultResetPc = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } fetch_state_e;

    typedef struct packed {
        logic [AddrWidth-1:0] pc;
        logic [InstWidth-1:0] inst;
    } fetch_entry_t;

    function automatic logic [AddrWidth-1:0] align_pc(input logic [AddrWidth-1:0] addr);
        return {addr[AddrWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_25040105_inst_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries for the decoder.
// Flush empties it in one cycle; simultaneous push and pop is legal even when full.
module ysyx_25040105_inst_fifo
    import ysyx_25040105_ifetch_pkg::*;
#(
    parameter int unsigned      Width      = EntryWidth,
    parameter int unsigned      Depth      = 2,
    parameter logic [Width-1:0] ResetEntry = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned         PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth:0]   PtrOne   = 1;

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrWidth-1:0] wr_idx, rd_idx;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign wr_idx = wr_ptr_q[PtrWidth-1:0];
    assign rd_idx = rd_ptr_q[PtrWidth-1:0];
    assign count  = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]);
    assign rdata  = mem_q[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= ResetEntry;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_idx] <= wdata;
                wr_ptr_q      <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

endmodule

// File: rtl/ysyx_25040105_ifetch.sv
// Instruction fetch unit: issues one memory request at a time, buffers responses for the
// decoder and handles redirects by flushing the buffer and dropping the in-flight response.
module ysyx_25040105_ifetch
    import ysyx_25040105_ifetch_pkg::*;
#(
    parameter logic [AddrWidth-1:0] RESET_PC  = DefaultResetPc,
    parameter int unsigned          BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [AddrWidth-1:0] redirect_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [AddrWidth-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [InstWidth-1:0] imem_rsp_data,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [InstWidth-1:0] inst,
    output logic [AddrWidth-1:0] pc
);

    localparam int unsigned          CntWidth = $clog2(BUF_DEPTH) + 1;
    localparam logic [CntWidth-1:0]  DepthCnt = CntWidth'(BUF_DEPTH);
    localparam logic [AddrWidth-1:0] PcStep   = 4;

    fetch_state_e         state_q, state_d;
    logic [AddrWidth-1:0] fetch_pc_q, fetch_pc_d;
    logic [AddrWidth-1:0] req_addr_q, req_addr_d;
    logic                 drop_q, drop_d;

    logic                 push, pop, flush;
    logic                 fifo_full, fifo_empty;
    logic [CntWidth-1:0]  count, count_after;
    fetch_entry_t         wr_entry, rd_entry;

    assign flush      = redirect_valid;
    assign inst_valid = !fifo_empty;
    // A redirect flushes the buffer; the popped head is consumed either way.
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign wr_entry   = '{pc: req_addr_q, inst: imem_rsp_data};
    assign inst       = rd_entry.inst;
    assign pc         = rd_entry.pc;
    assign imem_req_addr = fetch_pc_q;

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        req_addr_d     = req_addr_q;
        drop_d         = drop_q;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        count_after    = count;

        unique case (state_q)
            StIdle: begin
                if (!redirect_valid && !fifo_full) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    req_addr_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PcStep;
                    // Request went out for the old path; its response must be discarded.
                    drop_d     = redirect_valid;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    push        = !drop_q && !redirect_valid;
                    drop_d      = 1'b0;
                    count_after = redirect_valid ? '0
                                : count + CntWidth'(push) - CntWidth'(pop);
                    state_d     = (count_after < DepthCnt) ? StReq : StIdle;
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
        end
    end

    ysyx_25040105_inst_fifo #(
        .Width      (EntryWidth),
        .Depth      (BUF_DEPTH),
        .ResetEntry ({RESET_PC, {InstWidth{1'b0}}})
    ) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .flush (flush),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

endmodule

// File: tb/tb_ysyx_25040105_ifetch.sv
// Self-checking bench for the fetch unit: directed scenarios plus randomized traffic checked
// against a transaction-level model (expected fetch address, epoch-tagged responses, buffer queue).
module tb_ysyx_25040105_ifetch;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam int unsigned BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;

    always #5 clk = ~clk;

    ysyx_25040105_ifetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ref_entry_t;

    ref_entry_t  ref_q[$];
    logic [31:0] exp_fetch;
    bit          out_busy;
    logic [31:0] out_addr;
    int unsigned out_epoch, epoch, out_wait;

    int unsigned p_req_ready, p_inst_ready, p_redirect, dly_min, dly_max;
    bit          force_redir, fixed_data;
    logic [31:0] force_pc;
    int unsigned fire_cnt, pop_cnt;
    int unsigned vectors, miscompares;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (fixed_data) return 32'h0000_0013;
        return (a ^ 32'h5A3C_0F13) + {a[15:0], a[31:16]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        exp_fetch = RESET_PC;
        out_busy  = 1'b0;
        epoch++;
    endtask

    task automatic drive_idle();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance the model across the
    // next rising edge, then return at the following falling edge.
    task automatic step();
        bit          fire, do_pop, redir, busy_before;
        int unsigned occ_before;
        logic [31:0] tgt;

        check_eq("inst_valid", 32'(inst_valid), 32'(ref_q.size() != 0));
        if (ref_q.size() != 0) begin
            check_eq("head_pc", pc, ref_q[0].pc);
            check_eq("head_inst", inst, ref_q[0].inst);
        end

        imem_req_ready = ($urandom_range(99) < p_req_ready);
        inst_ready     = ($urandom_range(99) < p_inst_ready);
        redir          = force_redir || ($urandom_range(99) < p_redirect);
        tgt            = force_redir ? force_pc : (32'h8000_0000 | 32'($urandom_range(32'hFFF)));
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (out_busy) begin
            if (out_wait == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(out_addr);
            end else begin
                out_wait--;
            end
        end

        fire        = imem_req_valid && imem_req_ready;
        do_pop      = inst_valid && inst_ready && !redir;
        busy_before = out_busy;
        occ_before  = ref_q.size();

        if (fire) begin
            fire_cnt++;
            check_eq("req_addr", imem_req_addr, exp_fetch);
            check_eq("one_outstanding", 32'(busy_before), 32'd0);
            check_eq("space_at_req", 32'(occ_before < BUF_DEPTH), 32'd1);
        end
        if (do_pop && ref_q.size() != 0) begin
            pop_cnt++;
            void'(ref_q.pop_front());
        end
        if (imem_rsp_valid) begin
            if (!redir && out_epoch == epoch) begin
                ref_q.push_back('{out_addr, imem_rsp_data});
                check_eq("occupancy", 32'(ref_q.size() <= BUF_DEPTH), 32'd1);
            end
            out_busy = 1'b0;
        end
        if (fire) begin
            out_busy  = 1'b1;
            out_addr  = exp_fetch;
            out_epoch = epoch;
            out_wait  = $urandom_range(dly_max, dly_min);
        end
        if (redir) begin
            ref_q.delete();
            epoch++;
            exp_fetch = {tgt[31:2], 2'b00};
        end else if (fire) begin
            exp_fetch = exp_fetch + 32'd4;
        end

        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clk);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_pc", pc, RESET_PC);
        rst = 1'b1;
        @(negedge clk);
        check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("first_req_addr", imem_req_addr, RESET_PC);
    endtask

    initial begin
        int unsigned snap;
        bit          found;

        vectors = 0; miscompares = 0; epoch = 0; fire_cnt = 0; pop_cnt = 0;
        p_redirect = 0; force_redir = 1'b0; force_pc = '0; fixed_data = 1'b0;
        dly_min = 0; dly_max = 0;
        drive_idle();
        @(negedge clk);

        // First fetch and steady-state throughput with an always-ready memory and decoder.
        apply_reset();
        fixed_data = 1'b1; p_req_ready = 100; p_inst_ready = 100;
        step();
        check_eq("wait_after_accept", 32'(imem_req_valid), 32'd0);
        step();
        check_eq("first_inst_valid", 32'(inst_valid), 32'd1);
        check_eq("first_inst_pc", pc, 32'h8000_0000);
        check_eq("first_inst", inst, 32'h0000_0013);
        snap = pop_cnt;
        repeat (20) step();
        check_eq("throughput", pop_cnt - snap, 32'd10);
        fixed_data = 1'b0;

        // Decoder stalled: buffer fills to two entries and fetching stops.
        apply_reset();
        p_req_ready = 100; p_inst_ready = 0;
        snap = fire_cnt;
        repeat (12) step();
        check_eq("stall_fires", fire_cnt - snap, 32'd2);
        check_eq("stall_no_req", 32'(imem_req_valid), 32'd0);
        check_eq("stall_head_pc", pc, 32'h8000_0000);
        p_inst_ready = 100;
        step();
        check_eq("stall_second_pc", pc, 32'h8000_0004);

        // Redirect while waiting on memory: buffer flushed, response dropped, aligned restart.
        apply_reset();
        p_req_ready = 100; p_inst_ready = 0; dly_min = 0; dly_max = 0;
        step();
        dly_min = 2; dly_max = 2;
        step();
        step();
        check_eq("in_wait", 32'(imem_req_valid), 32'd0);
        check_eq("buffered_before_redirect", 32'(inst_valid), 32'd1);
        force_redir = 1'b1; force_pc = 32'h8000_0103;
        step();
        force_redir = 1'b0;
        check_eq("flush_empty", 32'(inst_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq("redirect_req_seen", 32'(found), 32'd1);
        check_eq("redirect_addr", imem_req_addr, 32'h8000_0100);
        repeat (6) step();

        // Memory back-pressure: address held stable, a single acceptance.
        apply_reset();
        p_req_ready = 0; p_inst_ready = 100; dly_min = 0; dly_max = 0;
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", 32'(imem_req_valid), 32'd1);
            check_eq("hold_addr", imem_req_addr, 32'h8000_0000);
            step();
        end
        p_req_ready = 100;
        snap = fire_cnt;
        step();
        check_eq("single_accept", fire_cnt - snap, 32'd1);
        check_eq("hold_then_wait", 32'(imem_req_valid), 32'd0);

        // Address wrap at the top of the address space.
        apply_reset();
        p_req_ready = 0; p_inst_ready = 100;
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
        step();
        force_redir = 1'b0;
        check_eq("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        p_req_ready = 100;
        step();
        step();
        check_eq("wrap_next_valid", 32'(imem_req_valid), 32'd1);
        check_eq("wrap_next_addr", imem_req_addr, 32'h0000_0000);

        // Reset while a request is outstanding; the late response must be ignored.
        apply_reset();
        p_req_ready = 100; p_inst_ready = 0; dly_min = 3; dly_max = 3;
        step();
        check_eq("pre_reset_wait", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("midrst_inst_valid", 32'(inst_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check_eq("restart_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("restart_req_addr", imem_req_addr, RESET_PC);
        dly_min = 0; dly_max = 0;
        repeat (4) step();
        check_eq("restart_inst_valid", 32'(inst_valid), 32'd1);
        check_eq("restart_pc", pc, RESET_PC);
        check_eq("restart_inst", inst, mem_word(RESET_PC));

        // Randomized traffic with redirects, back-pressure and variable latency.
        apply_reset();
        p_req_ready = 70; p_inst_ready = 60; p_redirect = 4; dly_min = 0; dly_max = 3;
        repeat (3000) step();
        p_inst_ready = 15; p_req_ready = 90; p_redirect = 2;
        repeat (1000) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
